rename_map_unit: RTL and testbench

Register-rename stage for the MIPS core, sitting between decode and the forwarding/issue logic. Maps architectural rs/rt/rw to physical registers, allocates a fresh physical destination from a free list, and tracks per-physical busy bits. Emits one registered rename packet per cycle to the forwarding unit, which consumes the `*_phys` addresses and busy state. Busy bits are cleared on writeback; the previous mapping of a destination is returned to the free list at commit.

---
 rtl/mips_core_pkg.sv | 19 +
 rtl/rename_free_list.sv | 55 +++++
 rtl/rename_map_unit.sv | 124 ++++++++++++
 tb/tb_rename_map_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared rename-stage types and sizing constants
package mips_core_pkg;

   localparam int NUM_ARCH   = 32;
   localparam int NUM_PHYS   = 64;
   localparam int FREE_DEPTH = NUM_PHYS - NUM_ARCH;

   typedef logic [5:0] PhysReg;
   typedef logic [4:0] ArchReg;

   // Busy as seen by a reader this cycle: a writeback landing now already counts as done.
   function automatic logic src_busy(input logic [NUM_PHYS-1:0] busy,
                                     input PhysReg               phys,
                                     input logic                 wb_valid,
                                     input PhysReg               wb_phys);
      return busy[phys] & ~(wb_valid & (wb_phys == phys)) & (phys != '0);
   endfunction

endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - circular FIFO of unmapped physical registers
module rename_free_list
   import mips_core_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [5:0] push_phys,
   input  logic       pop,
   output logic [5:0] pop_phys,
   output logic [5:0] count
);

   PhysReg     entries [FREE_DEPTH];
   logic [4:0] head;
   logic [4:0] tail;
   logic       do_push;
   logic       do_pop;

   // A push into an empty list is not visible to a pop in the same cycle.
   assign do_push  = push & (count != 6'(FREE_DEPTH));
   assign do_pop   = pop & (count != 6'd0);
   assign pop_phys = entries[head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FREE_DEPTH; i++) begin
            entries[i] <= PhysReg'(NUM_ARCH + i);
         end
         head  <= 5'd0;
         tail  <= 5'd0;
         count <= 6'(FREE_DEPTH);
      end else begin
         if (do_push) begin
            entries[tail] <= push_phys;
            tail          <= tail + 5'd1;
         end
         if (do_pop) begin
            head <= head + 5'd1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 6'd1;
            2'b01:   count <= count - 6'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         assert (count != 6'(FREE_DEPTH));
      end
   end

endmodule

// File: rtl/rename_map_unit.sv
// rtl/rename_map_unit.sv - rename stage: arch-to-phys map, free list, busy bits, registered packet
module rename_map_unit
   import mips_core_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_uses_rs,
   input  logic        i_uses_rt,
   input  logic        i_uses_rw,
   input  logic [4:0]  i_rs_addr,
   input  logic [4:0]  i_rt_addr,
   input  logic [4:0]  i_rw_addr,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_uses_rs,
   output logic        o_uses_rt,
   output logic        o_uses_rw,
   output logic [5:0]  o_rs_phys,
   output logic [5:0]  o_rt_phys,
   output logic [5:0]  o_rw_phys,
   output logic [5:0]  o_old_rw_phys,
   output logic        o_rs_busy,
   output logic        o_rt_busy,
   output logic [63:0] o_busy_bits,
   input  logic        i_wb_valid,
   input  logic [5:0]  i_wb_phys,
   input  logic        i_commit_valid,
   input  logic [5:0]  i_commit_old_phys,
   output logic [5:0]  o_free_count
);

   PhysReg              map_q [NUM_ARCH];
   logic [NUM_PHYS-1:0] busy_q;
   logic [NUM_PHYS-1:0] busy_d;
   logic [5:0]          free_count;
   PhysReg              new_phys;
   PhysReg              rs_phys;
   PhysReg              rt_phys;
   PhysReg              prev_rw_phys;
   logic                alloc;
   logic                fire;
   logic                do_pop;
   logic                do_push;

   assign alloc   = i_uses_rw & (i_rw_addr != 5'd0);
   assign o_ready = (~o_valid | i_ready) & (~alloc | (free_count != 6'd0));
   assign fire    = i_valid & o_ready;
   assign do_pop  = fire & alloc;
   assign do_push = i_commit_valid & (i_commit_old_phys != 6'd0);

   // Sources read the pre-update map, so "add r1,r1,r1" sees the old r1.
   assign rs_phys      = map_q[i_rs_addr];
   assign rt_phys      = map_q[i_rt_addr];
   assign prev_rw_phys = map_q[i_rw_addr];

   assign o_busy_bits  = busy_q;
   assign o_free_count = free_count;

   rename_free_list u_free_list (
      .clk       (clk),
      .rst       (rst),
      .push      (do_push),
      .push_phys (i_commit_old_phys),
      .pop       (do_pop),
      .pop_phys  (new_phys),
      .count     (free_count)
   );

   always_comb begin
      busy_d = busy_q;
      if (i_wb_valid) begin
         busy_d[i_wb_phys] = 1'b0;
      end
      if (do_pop) begin
         busy_d[new_phys] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ARCH; i++) begin
            map_q[i] <= PhysReg'(i);
         end
         busy_q <= '0;
      end else begin
         if (do_pop) begin
            map_q[i_rw_addr] <= new_phys;
         end
         busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid       <= 1'b0;
         o_uses_rs     <= 1'b0;
         o_uses_rt     <= 1'b0;
         o_uses_rw     <= 1'b0;
         o_rs_phys     <= '0;
         o_rt_phys     <= '0;
         o_rw_phys     <= '0;
         o_old_rw_phys <= '0;
         o_rs_busy     <= 1'b0;
         o_rt_busy     <= 1'b0;
      end else if (fire) begin
         o_valid       <= 1'b1;
         o_uses_rs     <= i_uses_rs;
         o_uses_rt     <= i_uses_rt;
         o_uses_rw     <= i_uses_rw;
         o_rs_phys     <= rs_phys;
         o_rt_phys     <= rt_phys;
         o_rw_phys     <= alloc ? new_phys : 6'd0;
         o_old_rw_phys <= alloc ? prev_rw_phys : 6'd0;
         o_rs_busy     <= src_busy(busy_q, rs_phys, i_wb_valid, i_wb_phys);
         o_rt_busy     <= src_busy(busy_q, rt_phys, i_wb_valid, i_wb_phys);
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rename_map_unit.sv
// tb/tb_rename_map_unit.sv - self-checking bench for rename_map_unit
module tb_rename_map_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, o_ready;
   logic        i_uses_rs, i_uses_rt, i_uses_rw;
   logic [4:0]  i_rs_addr, i_rt_addr, i_rw_addr;
   logic        o_valid, i_ready;
   logic        o_uses_rs, o_uses_rt, o_uses_rw;
   logic [5:0]  o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys;
   logic        o_rs_busy, o_rt_busy;
   logic [63:0] o_busy_bits;
   logic        i_wb_valid;
   logic [5:0]  i_wb_phys;
   logic        i_commit_valid;
   logic [5:0]  i_commit_old_phys;
   logic [5:0]  o_free_count;

   int n_checks = 0;
   int n_fail   = 0;

   int map_m [32];
   bit busy_m [64];
   int fl_m [$];
   int inflight [$];
   bit exp_valid, exp_urs, exp_urt, exp_urw, exp_rs_busy, exp_rt_busy;
   int exp_rs, exp_rt, exp_rw, exp_old;

   always #5 clk = ~clk;

   rename_map_unit dut (
      .clk               (clk),
      .rst               (rst),
      .i_valid           (i_valid),
      .o_ready           (o_ready),
      .i_uses_rs         (i_uses_rs),
      .i_uses_rt         (i_uses_rt),
      .i_uses_rw         (i_uses_rw),
      .i_rs_addr         (i_rs_addr),
      .i_rt_addr         (i_rt_addr),
      .i_rw_addr         (i_rw_addr),
      .o_valid           (o_valid),
      .i_ready           (i_ready),
      .o_uses_rs         (o_uses_rs),
      .o_uses_rt         (o_uses_rt),
      .o_uses_rw         (o_uses_rw),
      .o_rs_phys         (o_rs_phys),
      .o_rt_phys         (o_rt_phys),
      .o_rw_phys         (o_rw_phys),
      .o_old_rw_phys     (o_old_rw_phys),
      .o_rs_busy         (o_rs_busy),
      .o_rt_busy         (o_rt_busy),
      .o_busy_bits       (o_busy_bits),
      .i_wb_valid        (i_wb_valid),
      .i_wb_phys         (i_wb_phys),
      .i_commit_valid    (i_commit_valid),
      .i_commit_old_phys (i_commit_old_phys),
      .o_free_count      (o_free_count)
   );

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) map_m[i] = i;
      for (int i = 0; i < 64; i++) busy_m[i] = 1'b0;
      fl_m.delete();
      for (int i = 32; i < 64; i++) fl_m.push_back(i);
      inflight.delete();
      exp_valid = 0; exp_urs = 0; exp_urt = 0; exp_urw = 0;
      exp_rs_busy = 0; exp_rt_busy = 0;
      exp_rs = 0; exp_rt = 0; exp_rw = 0; exp_old = 0;
   endfunction

   function automatic bit model_ready();
      bit alloc;
      alloc = i_uses_rw && (i_rw_addr != 0);
      return (!exp_valid || i_ready) && (!alloc || fl_m.size() != 0);
   endfunction

   function automatic logic [63:0] busy_vec();
      logic [63:0] v;
      for (int i = 0; i < 64; i++) v[i] = busy_m[i];
      return v;
   endfunction

   // Advance the reference model with the current inputs, then clock the DUT.
   task automatic tick();
      bit rdy, alloc, fire;
      rdy   = model_ready();
      alloc = i_uses_rw && (i_rw_addr != 0);
      fire  = i_valid && rdy;
      if (fire) begin
         exp_valid = 1;
         exp_urs = i_uses_rs; exp_urt = i_uses_rt; exp_urw = i_uses_rw;
         exp_rs = map_m[i_rs_addr];
         exp_rt = map_m[i_rt_addr];
         exp_rs_busy = (exp_rs != 0) && busy_m[exp_rs] && !(i_wb_valid && i_wb_phys == exp_rs);
         exp_rt_busy = (exp_rt != 0) && busy_m[exp_rt] && !(i_wb_valid && i_wb_phys == exp_rt);
         if (alloc) begin
            exp_old = map_m[i_rw_addr];
            exp_rw  = fl_m.pop_front();
            map_m[i_rw_addr] = exp_rw;
            inflight.push_back(exp_old);
         end else begin
            exp_old = 0;
            exp_rw  = 0;
         end
      end else if (i_ready) begin
         exp_valid = 0;
      end
      if (i_wb_valid && i_wb_phys != 0) busy_m[i_wb_phys] = 1'b0;
      if (fire && alloc) busy_m[exp_rw] = 1'b1;
      if (i_commit_valid && i_commit_old_phys != 0) fl_m.push_back(int'(i_commit_old_phys));
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit urs, input int rs, input bit urt, input int rt,
                        input bit urw, input int rw);
      i_valid = v;
      i_uses_rs = urs; i_rs_addr = 5'(rs);
      i_uses_rt = urt; i_rt_addr = 5'(rt);
      i_uses_rw = urw; i_rw_addr = 5'(rw);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      i_ready = 1'b1;
      i_wb_valid = 1'b0; i_wb_phys = '0;
      i_commit_valid = 1'b0; i_commit_old_phys = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
      n_checks++; if (o_free_count !== 6'd32) begin n_fail++; $display("FAIL reset_count: got %0d expected 32", o_free_count); end
      n_checks++; if (o_busy_bits !== 64'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", o_busy_bits); end
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", o_ready); end
      n_checks++; if (o_rw_phys !== 6'd0) begin n_fail++; $display("FAIL reset_rw_phys: got %0d expected 0", o_rw_phys); end
      drive(1, 1, 5, 1, 0, 0, 0);
      tick();
      n_checks++; if (o_valid !== 1'b1 || o_rs_phys !== 6'd5) begin n_fail++; $display("FAIL reset_map5: got valid %0b phys %0d expected 1/5", o_valid, o_rs_phys); end
   endtask

   task automatic test_dependency();
      do_reset();
      drive(1, 1, 1, 1, 2, 1, 3);
      tick();
      n_checks++; if (o_rw_phys !== 6'd32 || o_old_rw_phys !== 6'd3) begin n_fail++; $display("FAIL dep_first: got rw %0d old %0d expected 32/3", o_rw_phys, o_old_rw_phys); end
      n_checks++; if (o_rs_phys !== 6'd1 || o_rt_phys !== 6'd2) begin n_fail++; $display("FAIL dep_first_src: got %0d/%0d expected 1/2", o_rs_phys, o_rt_phys); end
      drive(1, 1, 3, 1, 3, 1, 4);
      tick();
      n_checks++; if (o_rs_phys !== 6'd32 || o_rt_phys !== 6'd32) begin n_fail++; $display("FAIL dep_second_src: got %0d/%0d expected 32/32", o_rs_phys, o_rt_phys); end
      n_checks++; if (o_rs_busy !== 1'b1 || o_rt_busy !== 1'b1) begin n_fail++; $display("FAIL dep_busy: got %0b/%0b expected 1/1", o_rs_busy, o_rt_busy); end
      n_checks++; if (o_rw_phys !== 6'd33 || o_old_rw_phys !== 6'd4) begin n_fail++; $display("FAIL dep_second_rw: got %0d/%0d expected 33/4", o_rw_phys, o_old_rw_phys); end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL dep_drain: got %0b expected 0", o_valid); end
      n_checks++; if (o_busy_bits !== ((64'd1 << 32) | (64'd1 << 33))) begin n_fail++; $display("FAIL dep_busy_vec: got %h expected 0000000300000000", o_busy_bits); end
   endtask

   task automatic test_exhaust();
      do_reset();
      for (int i = 0; i < 32; i++) begin
         drive(1, 0, 0, 0, 0, 1, (i % 31) + 1);
         tick();
      end
      n_checks++; if (o_free_count !== 6'd0) begin n_fail++; $display("FAIL exh_count: got %0d expected 0", o_free_count); end
      drive(1, 0, 0, 0, 0, 1, 9);
      i_commit_valid = 1'b1; i_commit_old_phys = 6'd7;
      #1;
      n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL exh_stall: got %0b expected 0", o_ready); end
      tick();
      i_commit_valid = 1'b0;
      #1;
      n_checks++; if (o_free_count !== 6'd1 || o_ready !== 1'b1) begin n_fail++; $display("FAIL exh_refill: got count %0d ready %0b expected 1/1", o_free_count, o_ready); end
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL exh_bubble: got %0b expected 0", o_valid); end
      tick();
      n_checks++; if (o_valid !== 1'b1 || o_rw_phys !== 6'd7) begin n_fail++; $display("FAIL exh_reuse: got valid %0b rw %0d expected 1/7", o_valid, o_rw_phys); end
      n_checks++; if (o_free_count !== 6'd0) begin n_fail++; $display("FAIL exh_count2: got %0d expected 0", o_free_count); end
   endtask

   task automatic test_wb_bypass();
      do_reset();
      drive(1, 0, 0, 0, 0, 1, 3);
      tick();
      n_checks++; if (o_busy_bits[32] !== 1'b1) begin n_fail++; $display("FAIL wb_set: got %0b expected 1", o_busy_bits[32]); end
      drive(1, 1, 3, 1, 3, 0, 0);
      i_wb_valid = 1'b1; i_wb_phys = 6'd32;
      tick();
      i_wb_valid = 1'b0;
      n_checks++; if (o_rs_phys !== 6'd32 || o_rs_busy !== 1'b0 || o_rt_busy !== 1'b0) begin n_fail++; $display("FAIL wb_bypass: got phys %0d busy %0b/%0b expected 32/0/0", o_rs_phys, o_rs_busy, o_rt_busy); end
      n_checks++; if (o_busy_bits[32] !== 1'b0) begin n_fail++; $display("FAIL wb_clear: got %0b expected 0", o_busy_bits[32]); end
   endtask

   task automatic test_self_dep();
      do_reset();
      drive(1, 1, 1, 1, 1, 1, 1);
      tick();
      n_checks++; if (o_rs_phys !== 6'd1 || o_rw_phys !== 6'd32 || o_old_rw_phys !== 6'd1) begin n_fail++; $display("FAIL self_dep: got rs %0d rw %0d old %0d expected 1/32/1", o_rs_phys, o_rw_phys, o_old_rw_phys); end
      drive(1, 1, 1, 0, 0, 1, 0);
      tick();
      n_checks++; if (o_rw_phys !== 6'd0 || o_old_rw_phys !== 6'd0 || o_uses_rw !== 1'b1) begin n_fail++; $display("FAIL r0_dest: got rw %0d old %0d uses %0b expected 0/0/1", o_rw_phys, o_old_rw_phys, o_uses_rw); end
      n_checks++; if (o_free_count !== 6'd31 || o_rs_phys !== 6'd32) begin n_fail++; $display("FAIL r0_count: got count %0d rs %0d expected 31/32", o_free_count, o_rs_phys); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, i, 0, 0, 1, i + 1);
         tick();
      end
      n_checks++; if (o_valid !== 1'b1 || o_free_count !== 6'd22) begin n_fail++; $display("FAIL mid_pre: got valid %0b count %0d expected 1/22", o_valid, o_free_count); end
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (o_valid !== 1'b0 || o_free_count !== 6'd32 || o_busy_bits !== 64'd0) begin n_fail++; $display("FAIL mid_async: got valid %0b count %0d busy %h expected 0/32/0", o_valid, o_free_count, o_busy_bits); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive(1, 1, 10, 1, 3, 0, 0);
      tick();
      n_checks++; if (o_rs_phys !== 6'd10 || o_rt_phys !== 6'd3 || o_rs_busy !== 1'b0) begin n_fail++; $display("FAIL mid_identity: got %0d/%0d busy %0b expected 10/3/0", o_rs_phys, o_rt_phys, o_rs_busy); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 800; c++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 31),
               $urandom_range(0, 1), $urandom_range(0, 31),
               $urandom_range(0, 3) != 0, $urandom_range(0, 31));
         i_ready = $urandom_range(0, 3) != 0;
         i_wb_valid = $urandom_range(0, 1);
         i_wb_phys = 6'($urandom_range(0, 63));
         i_commit_valid = (inflight.size() > 0) && ($urandom_range(0, 9) < 4);
         if (i_commit_valid) i_commit_old_phys = 6'(inflight.pop_front());
         else i_commit_old_phys = 6'($urandom_range(0, 63));
         #1;
         n_checks++; if (o_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready cycle %0d: got %0b expected %0b", c, o_ready, model_ready()); end
         tick();
         n_checks++; if (o_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid cycle %0d: got %0b expected %0b", c, o_valid, exp_valid); end
         if (exp_valid) begin
            n_checks++;
            if (o_rs_phys !== 6'(exp_rs) || o_rt_phys !== 6'(exp_rt) || o_rw_phys !== 6'(exp_rw) ||
                o_old_rw_phys !== 6'(exp_old) || o_rs_busy !== exp_rs_busy || o_rt_busy !== exp_rt_busy ||
                o_uses_rs !== exp_urs || o_uses_rt !== exp_urt || o_uses_rw !== exp_urw) begin
               n_fail++;
               $display("FAIL rnd_packet cycle %0d: got rs %0d rt %0d rw %0d old %0d busy %0b%0b expected rs %0d rt %0d rw %0d old %0d busy %0b%0b",
                        c, o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys, o_rs_busy, o_rt_busy,
                        exp_rs, exp_rt, exp_rw, exp_old, exp_rs_busy, exp_rt_busy);
            end
         end
         n_checks++; if (o_free_count !== 6'(fl_m.size())) begin n_fail++; $display("FAIL rnd_count cycle %0d: got %0d expected %0d", c, o_free_count, fl_m.size()); end
         n_checks++; if (o_busy_bits !== busy_vec()) begin n_fail++; $display("FAIL rnd_busy cycle %0d: got %h expected %h", c, o_busy_bits, busy_vec()); end
      end
      i_commit_valid = 1'b0;
      i_wb_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_dependency();
      test_exhaust();
      test_wb_bypass();
      test_self_dep();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
